// File: rtl/system_led_pio_pwm.sv
// Avalon-MM LED output port with per-bit static or PWM drive, atomic SET/CLR,
// global duty cycle and programmable prescaler.
module system_led_pio_pwm #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
    parameter int unsigned            PWM_BITS    = 8,
    parameter int unsigned            PRESC_BITS  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned DUTY_W = PWM_BITS + 1;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_MODE   = 3'd3;
    localparam logic [2:0] ADDR_DUTY   = 3'd4;
    localparam logic [2:0] ADDR_PRESC  = 3'd5;
    localparam logic [2:0] ADDR_PWMCNT = 3'd6;

    logic [WIDTH-1:0]      data;
    logic [WIDTH-1:0]      mode;
    logic [DUTY_W-1:0]     duty;
    logic [PRESC_BITS-1:0] presc;
    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;

    logic wr_en;
    logic tick;
    logic pwm_on;
    logic presc_restart;
    logic unused_wd;

    assign wr_en         = chipselect & ~write_n;
    assign tick          = (presc_cnt == presc);
    assign pwm_on        = ({1'b0, pwm_cnt} < duty);
    assign presc_restart = wr_en & ((address == ADDR_DUTY) | (address == ADDR_PRESC));
    assign unused_wd     = ^writedata;

    // Bus-visible configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= RESET_VALUE;
            mode  <= '0;
            duty  <= '0;
            presc <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:  data  <= writedata[WIDTH-1:0];
                ADDR_SET:   data  <= data | writedata[WIDTH-1:0];
                ADDR_CLR:   data  <= data & ~writedata[WIDTH-1:0];
                ADDR_MODE:  mode  <= writedata[WIDTH-1:0];
                ADDR_DUTY:  duty  <= writedata[DUTY_W-1:0];
                ADDR_PRESC: presc <= writedata[PRESC_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Prescaler restarts on DUTY/PRESC writes so a smaller terminal value is never skipped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (presc_restart || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_BITS'(1);
        end
    end

    // PWM counter, free-running modulo 2^PWM_BITS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // LED drive: static bits follow data, PWM bits are gated by the duty compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= data & (~mode | {WIDTH{pwm_on}});
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data);
            ADDR_MODE:   readdata = 32'(mode);
            ADDR_DUTY:   readdata = 32'(duty);
            ADDR_PRESC:  readdata = 32'(presc);
            ADDR_PWMCNT: readdata = 32'(pwm_cnt);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_system_led_pio_pwm.sv
// Directed bench for system_led_pio_pwm: WIDTH=8, RESET_VALUE=A5, PWM_BITS=4.
module tb_system_led_pio_pwm;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int total;
    int bad;

    system_led_pio_pwm #(
        .WIDTH      (8),
        .RESET_VALUE(8'hA5),
        .PWM_BITS   (4),
        .PRESC_BITS (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle; the write edge is the posedge inside, returns on the following negedge
    task automatic bus_write(input logic cs, input logic [2:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chipselect = cs;
        write_n    = 1'b0;
        address    = addr;
        writedata  = wd;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        chipselect = 1'b1;
        address    = addr;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    logic [7:0] samp [48];
    int first_rise;
    int highs;
    int nonmatch;
    int waited;

    initial begin
        total = 0;
        bad = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_port", 32'(out_port), 32'h0000_00A5);
        read_check("reset_data",   3'd0, 32'h0000_00A5);
        read_check("reset_mode",   3'd3, 32'h0);
        read_check("reset_duty",   3'd4, 32'h0);
        read_check("reset_presc",  3'd5, 32'h0);
        read_check("reset_pwmcnt", 3'd6, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // DATA / SET / CLR, each visible one cycle after its write edge
        bus_write(1'b1, 3'd0, 32'h0000_003C);
        check("data_latency", 32'(out_port), 32'h0000_00A5);
        @(negedge clk);
        check("data_out", 32'(out_port), 32'h0000_003C);
        bus_write(1'b1, 3'd1, 32'hFFFF_FF81);
        @(negedge clk);
        check("set_out", 32'(out_port), 32'h0000_00BD);
        bus_write(1'b1, 3'd2, 32'h0000_000C);
        check("clr_latency", 32'(out_port), 32'h0000_00BD);
        @(negedge clk);
        check("clr_out", 32'(out_port), 32'h0000_00B1);
        read_check("read_set", 3'd1, 32'h0);
        read_check("read_clr", 3'd2, 32'h0);
        read_check("read_data", 3'd0, 32'h0000_00B1);

        // Deselected write and writes to read-only / unused addresses
        bus_write(1'b0, 3'd0, 32'h0000_0000);
        read_check("cs0_write_ignored", 3'd0, 32'h0000_00B1);
        bus_write(1'b1, 3'd7, 32'hFFFF_FFFF);
        read_check("addr7_reads_zero", 3'd7, 32'h0);
        read_check("addr7_data_kept", 3'd0, 32'h0000_00B1);

        // PWM: MODE=FF with DUTY=0 is dark, DUTY=16 is fully on
        bus_write(1'b1, 3'd0, 32'h0000_00FF);
        bus_write(1'b1, 3'd3, 32'h0000_00FF);
        @(negedge clk);
        check("duty0_dark", 32'(out_port), 32'h0);
        bus_write(1'b1, 3'd4, 32'h0000_0010);
        read_check("read_duty16", 3'd4, 32'h0000_0010);
        @(negedge clk);
        nonmatch = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_port !== 8'hFF) nonmatch++;
            @(negedge clk);
        end
        check("duty16_always_on", 32'(nonmatch), 32'h0);

        // DUTY=4: on 4 of every 16 cycles
        bus_write(1'b1, 3'd4, 32'h0000_0004);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            samp[i] = out_port;
            @(negedge clk);
        end
        first_rise = -1;
        for (int i = 1; i < 32; i++)
            if (first_rise < 0 && samp[i] == 8'hFF && samp[i-1] == 8'h00) first_rise = i;
        check("duty4_rise_found", 32'(first_rise >= 0), 32'h1);
        if (first_rise < 0) first_rise = 1;
        highs = 0;
        for (int i = 0; i < 16; i++)
            if (samp[first_rise + i] == 8'hFF) highs++;
        check("duty4_on_count", 32'(highs), 32'd4);
        check("duty4_on_run", {24'h0, samp[first_rise + 3]}, 32'h0000_00FF);
        check("duty4_off_after", {24'h0, samp[first_rise + 4]}, 32'h0);
        check("duty4_period", {24'h0, samp[first_rise + 16]}, 32'h0000_00FF);
        check("duty4_period_prev", {24'h0, samp[first_rise + 15]}, 32'h0);

        // DUTY=0 stays dark; partial MODE leaves static bits lit
        bus_write(1'b1, 3'd4, 32'h0000_0000);
        repeat (2) @(negedge clk);
        nonmatch = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_port !== 8'h00) nonmatch++;
            @(negedge clk);
        end
        check("duty0_never_on", 32'(nonmatch), 32'h0);
        bus_write(1'b1, 3'd3, 32'h0000_000F);
        @(negedge clk);
        check("mode0f_out", 32'(out_port), 32'h0000_00F0);

        // Prescaler from a known counter state after reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(1'b1, 3'd5, 32'h0000_0003);
        read_check("presc3_pwmcnt_start", 3'd6, 32'd2);
        read_check("read_presc", 3'd5, 32'd3);
        repeat (3) @(negedge clk);
        read_check("presc3_hold", 3'd6, 32'd2);
        @(negedge clk);
        read_check("presc3_tick", 3'd6, 32'd3);
        bus_write(1'b1, 3'd5, 32'h0000_0001);
        read_check("presc1_after_write", 3'd6, 32'd3);
        @(negedge clk);
        read_check("presc1_hold", 3'd6, 32'd3);
        @(negedge clk);
        read_check("presc1_tick", 3'd6, 32'd4);

        // Asynchronous reset in the middle of a PWM period
        bus_write(1'b1, 3'd5, 32'h0000_0000);
        bus_write(1'b1, 3'd0, 32'h0000_00FF);
        bus_write(1'b1, 3'd3, 32'h0000_00FF);
        bus_write(1'b1, 3'd4, 32'h0000_0010);
        chipselect = 1'b1;
        address    = 3'd6;
        waited = 0;
        #1;
        while (readdata[3:0] !== 4'd9 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("pwmcnt9_reached", 32'(waited < 40), 32'h1);
        check("pre_reset_out", 32'(out_port), 32'h0000_00FF);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out_port), 32'h0000_00A5);
        check("async_reset_pwmcnt", readdata, 32'h0);
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
